// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD down counter used as an interval timer.
// A decimal value is loaded, started, and counted down on each tick while
// running; done pulses for one cycle when the count is decremented to zero.
//
// state | meaning
// IDLE  | stopped; load and start accepted
// RUN   | counting down on tick; pause moves to HOLD
// HOLD  | count frozen; load or resume via start
module bcd_countdown_timer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  input  logic                  start_i,
  input  logic                  pause_i,
  input  logic                  tick_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  zero_o,
  output logic                  load_err_o
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           load_err_q, load_err_d;
  logic           load_ok;
  logic [W-1:0]   count_dec;

  // Borrow ripples from digit 0 upward; a zero digit under borrow becomes 9.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    logic [3:0]   dig;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig = v[4*i +: 4];
      if (borrow) begin
        if (dig == 4'd0) begin
          dig = 4'd9;
        end else begin
          dig    = dig - 4'd1;
          borrow = 1'b0;
        end
      end
      r[4*i +: 4] = dig;
    end
    return r;
  endfunction

  // A load is accepted only if every digit is a legal BCD digit.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val_i[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  assign count_dec = bcd_dec(count_q);

  // Next-state, count, done and load-error decisions.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_d     = 1'b0;
    load_err_d = load_err_q;
    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          if (load_ok) begin
            count_d    = load_val_i;
            load_err_d = 1'b0;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (start_i && (count_q != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pause_i) begin
          state_d = HOLD;
        end else if (tick_i && (count_q != '0)) begin
          count_d = count_dec;
          if (count_q == ONE) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (load_i) begin
          if (load_ok) begin
            count_d    = load_val_i;
            load_err_d = 1'b0;
            if (load_val_i == '0) state_d = IDLE;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (start_i && !pause_i) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; synchronous reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_o    = count_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign zero_o     = (count_q == '0);
  assign load_err_o = load_err_q;

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Multi-digit BCD down counter with load, start, pause and terminal-count pulse. It is the count-down complement of the team's decade up-counter. Used as a loadable interval timer: software or an FSM loads a decimal value, starts it, and receives `done` when the count reaches zero. A `tick` input lets it run from a prescaled time base, not every clock.

Parameters:
DIGITS, 4, number of BCD digits; count width = 4*DIGITS; legal range 1..8.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
load  input  1  load request; sampled only in IDLE or HOLD.
load_val  input  4*DIGITS  BCD value to load; digit 0 in bits [3:0].
start  input  1  start request; IDLE->RUN or HOLD->RUN.
pause  input  1  pause request; RUN->HOLD.
tick  input  1  decrement enable, honoured only in RUN.
count  output  4*DIGITS  current BCD count, registered.
busy  output  1  1 when state is RUN or HOLD.
done  output  1  one-cycle pulse when count reaches zero by decrement.
zero  output  1  combinational: count == 0.
load_err  output  1  sticky flag: last load attempt had a non-BCD digit.

Behaviour:
- Reset (rst=1 at posedge) dominates all inputs:
  - count=0, state=IDLE, busy=0, done=0, load_err=0; zero=1 follows from count.
- States: IDLE, RUN, HOLD. busy = (state != IDLE), registered with the state.
- IDLE:
  - load=1: if every digit of load_val is <= 9, count<=load_val and load_err<=0. Otherwise count unchanged and load_err<=1.
  - start=1 with count != 0, and no load that cycle: state<=RUN.
  - start=1 with count == 0: ignored; no done pulse.
  - load and start in the same cycle: load wins; start ignored.
- RUN, with priority pause > tick:
  - pause=1: state<=HOLD; no decrement that cycle, even if tick=1.
  - else tick=1: count decrements by one in BCD.
  - load and start ignored in RUN.
- BCD decrement, per digit from digit 0 upward:
  - If the incoming borrow is 1: a digit of 0 becomes 9 and passes the borrow on; any other digit decrements by 1 and passes no borrow.
  - Digit 0's incoming borrow is 1.
  - Example: 1000 -> 0999.
- Terminal count: when count == 1 (all upper digits 0, digit 0 = 1) and a tick decrements it, on that edge:
  - count<=0, done<=1, state<=IDLE (busy<=0).
  - done is high for exactly one cycle.
  - The counter never wraps below zero.
- HOLD:
  - count frozen; tick ignored.
  - start=1 and pause=0: state<=RUN.
  - start and pause both 1: remain in HOLD.
  - load=1: same validity rule as in IDLE. If the result is count==0, state<=IDLE with no done pulse; otherwise remain in HOLD.
- Latency:
  - start at edge k puts the block in RUN after edge k.
  - The first decrement happens on the first edge after k where tick=1.
  - A tick in the same cycle as the accepted start is not counted.
- load_err is held until the next valid load or reset. An invalid load never alters count or state.
- rst asserted mid-RUN or mid-HOLD: next edge gives count=0, IDLE, with no done pulse.
- count only ever holds valid BCD digits.

Test Plan:
1. Reset: assert rst for 2 cycles with random inputs -> count=0000, busy=0, done=0, zero=1, load_err=0.
2. Basic run, DIGITS=4:
   - Stimulus: load 0012, start, then tick every cycle.
   - Required: count steps 0011, 0010, 0009, ..., 0001, 0000.
   - done=1 for exactly the one cycle where count first reads 0000; busy drops at that same cycle.
   - Exactly 12 ticks consumed.
3. Borrow chain:
   - Load 1000, start, one tick -> count=0999.
   - Load 0100 in HOLD, resume, one tick -> 0099.
4. Invalid load:
   - Load 00A5 after count=0042 -> load_err=1, count stays 0042.
   - Subsequent load 0007 -> load_err=0, count=0007.
5. Pause/resume and priority:
   - In RUN at 0050, assert pause and tick together -> HOLD, count stays 0050.
   - Ticks in HOLD ignored.
   - start and pause together -> stays HOLD.
   - start alone -> RUN; next tick gives 0049.
6. Ignored and abort cases:
   - start with count 0000 -> stays IDLE, no done.
   - load 0300 during RUN -> ignored.
   - rst at count 0033 in RUN -> 0000, IDLE, done never pulses.
